// File: rtl/cache_pkg.sv
// cache_pkg: line geometry constants and line-transfer FSM encoding
package cache_pkg;
   localparam int ADDR_W     = 32;
   localparam int WORD_W     = 8;
   localparam int LINE_WORDS = 8;
   localparam int OFFSET_W   = $clog2(LINE_WORDS);
   localparam int LINE_W     = WORD_W * LINE_WORDS;
   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;
endpackage

// File: rtl/line_fill_engine.sv
// line_fill_engine: serialises victim writeback and line refill into byte-wide memory accesses
module line_fill_engine
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wb,
   input  logic [ADDR_W-1:0] req_wb_addr,
   input  logic [LINE_W-1:0] req_wb_line,
   input  logic [ADDR_W-1:0] req_fill_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [LINE_W-1:0] resp_line,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [WORD_W-1:0] mem_rdata
);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);
   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]   wb_base_q, fill_base_q;
   logic [LINE_W-1:0]   wb_line_q, resp_line_q;
   logic                accept, last;
   assign accept = req_valid && (state_q == IDLE);
   assign last   = &cnt_q;
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // next state and byte counter; counter wraps naturally at the end of each phase
   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == WB || state_q == FILL) ? cnt_q + OFFSET_W'(1) : '0;
      case (state_q)
         IDLE:    if (req_valid) state_d = req_wb ? WB : FILL;
         WB:      if (last) state_d = FILL;
         FILL:    if (last) state_d = RESP;
         default: if (resp_ready) state_d = IDLE;
      endcase
   end
   // outputs decoded from state; RESP keeps pointing at the last fill byte
   always_comb begin
      req_ready  = (state_q == IDLE);
      busy       = (state_q != IDLE);
      resp_valid = (state_q == RESP);
      mem_we     = (state_q == WB);
      mem_addr   = (state_q == WB)   ? wb_base_q | ADDR_W'(cnt_q) :
                   (state_q == FILL) ? fill_base_q | ADDR_W'(cnt_q) :
                   (state_q == RESP) ? fill_base_q | OFF_MASK : '0;
      mem_wdata  = (state_q == WB) ? wb_line_q[WORD_W*cnt_q +: WORD_W] : '0;
      resp_line  = resp_line_q;
   end
   // request capture on acceptance only, and byte-wise fill reassembly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         wb_line_q   <= '0;
         resp_line_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            fill_base_q <= req_fill_addr & ~OFF_MASK;
            if (req_wb) begin
               wb_base_q <= req_wb_addr & ~OFF_MASK;
               wb_line_q <= req_wb_line;
            end
         end
         if (state_q == FILL) resp_line_q[WORD_W*cnt_q +: WORD_W] <= mem_rdata;
      end
   end
endmodule
